// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the SFU issue path.
//   - sfu_op_e          : SFU op-type encoding
//   - inst_sfu_is_fence : true for warp-control ops that must fence issue
//   - sfu_isw_width     : issue-slot index width, never below 1
//   - PERF_CTR_BITS     : width of performance counters
package VX_gpu_pkg;

  localparam int unsigned PERF_CTR_BITS = 16;
  localparam int unsigned SFU_OP_W      = 4;

  typedef enum logic [SFU_OP_W-1:0] {
    SFU_OP_TMC    = 4'd0,
    SFU_OP_WSPAWN = 4'd1,
    SFU_OP_SPLIT  = 4'd2,
    SFU_OP_JOIN   = 4'd3,
    SFU_OP_BAR    = 4'd4,
    SFU_OP_PRED   = 4'd5,
    SFU_OP_CSR    = 4'd6
  } sfu_op_e;

  // Barrier and join reconverge/stall warps, so nothing may issue past them.
  function automatic logic inst_sfu_is_fence(input sfu_op_e op_type);
    return (op_type == SFU_OP_JOIN) || (op_type == SFU_OP_BAR);
  endfunction

  function automatic int unsigned sfu_isw_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfu_issue_arbiter_queue.sv
// Two-entry elastic FIFO of {data, isw}; head entry drives the outputs
// straight from flops.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   push_i/push_data_i/push_isw_i : enqueue request and entry
//   pop_ready_i                : downstream accept of the head entry
//   full_o                     : two entries held (registered)
//   valid_o/data_o/isw_o       : head entry (registered)
module sfu_issue_arbiter_queue #(
  parameter int unsigned DATAW = 128,
  parameter int unsigned ISW_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DATAW-1:0] push_data_i,
  input  logic [ISW_W-1:0] push_isw_i,
  input  logic             pop_ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [DATAW-1:0] data_o,
  output logic [ISW_W-1:0] isw_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [DATAW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [ISW_W-1:0] i0_q, i0_d, i1_q, i1_d;
  logic             pop;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    i0_d  = i0_q;
    d1_d  = d1_q;
    i1_d  = i1_q;
    pop   = (cnt_q != 2'd0) && pop_ready_i;
    unique case ({push_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          d0_d = push_data_i;
          i0_d = push_isw_i;
        end else begin
          d1_d = push_data_i;
          i1_d = push_isw_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        d0_d  = d1_q;
        i0_d  = i1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          d0_d = push_data_i;
          i0_d = push_isw_i;
        end else begin
          d0_d = d1_q;
          i0_d = i1_q;
          d1_d = push_data_i;
          i1_d = push_isw_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      i0_q  <= '0;
      d1_q  <= '0;
      i1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      d0_q  <= d0_d;
      i0_q  <= i0_d;
      d1_q  <= d1_d;
      i1_q  <= i1_d;
    end
  end

  assign full_o  = cnt_q[1];
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = d0_q;
  assign isw_o   = i0_q;

endmodule

// File: rtl/sfu_issue_arbiter.sv
// Round-robin arbiter from ISSUE_WIDTH dispatch slots into the single SFU
// execute stream, with a 2-entry output queue and a warp-control fence.
// Optional build macro: SFU_ISSUE_ARB_PERF_EN adds perf_fence_stalls.
// Ports:
//   clk, reset                     : clock, async active-low reset
//   disp_valid/disp_data/disp_fence: per-slot dispatch request
//   disp_ready                     : per-slot accept (combinational)
//   exe_valid/exe_data/exe_isw     : execute op from queue head (registered)
//   exe_ready                      : execute accept
//   fence_clear                    : pulse when the fenced op commits
//   fence_active                   : high while new grants are blocked
//   perf_fence_stalls              : saturating fenced-with-demand cycles
module sfu_issue_arbiter
  import VX_gpu_pkg::*;
#(
  parameter  int unsigned ISSUE_WIDTH = 4,
  parameter  int unsigned DATAW       = 128,
  localparam int unsigned ISW_W       = sfu_isw_width(ISSUE_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ISSUE_WIDTH-1:0]       disp_valid,
  input  logic [ISSUE_WIDTH*DATAW-1:0] disp_data,
  input  logic [ISSUE_WIDTH-1:0]       disp_fence,
  output logic [ISSUE_WIDTH-1:0]       disp_ready,
  output logic                         exe_valid,
  output logic [DATAW-1:0]             exe_data,
  output logic [ISW_W-1:0]             exe_isw,
  input  logic                         exe_ready,
  input  logic                         fence_clear,
  output logic                         fence_active
`ifdef SFU_ISSUE_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]     perf_fence_stalls
`endif
);

  typedef enum logic {ST_OPEN = 1'b0, ST_FENCED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ISW_W-1:0] rr_q, rr_d;
  logic [ISW_W-1:0] win;
  logic             grant;
  logic             q_full;
  logic             fence_active_q;
  int unsigned      slot;

  // First valid slot at or above the rr pointer, wrapping; disp_ready held
  // low while reset is asserted so nothing handshakes into a clearing queue.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    win        = '0;
    grant      = 1'b0;
    disp_ready = '0;
    slot       = 0;
    if (reset && (state_q == ST_OPEN) && !q_full) begin
      for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
        slot = 32'(rr_q) + k;
        if (slot >= ISSUE_WIDTH) slot = slot - ISSUE_WIDTH;
        if (!grant && disp_valid[ISW_W'(slot)]) begin
          grant = 1'b1;
          win   = ISW_W'(slot);
        end
      end
    end
    if (grant) begin
      disp_ready[win] = 1'b1;
      rr_d = (32'(win) == ISSUE_WIDTH - 1) ? '0 : win + ISW_W'(1);
    end
    unique case (state_q)
      ST_OPEN:   if (grant && disp_fence[win]) state_d = ST_FENCED;
      ST_FENCED: if (fence_clear)              state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_OPEN;
      rr_q           <= '0;
      fence_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      fence_active_q <= (state_d == ST_FENCED);
    end
  end

  assign fence_active = fence_active_q;

  sfu_issue_arbiter_queue #(
    .DATAW (DATAW),
    .ISW_W (ISW_W)
  ) u_queue (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (grant),
    .push_data_i (disp_data[32'(win)*DATAW +: DATAW]),
    .push_isw_i  (win),
    .pop_ready_i (exe_ready),
    .full_o      (q_full),
    .valid_o     (exe_valid),
    .data_o      (exe_data),
    .isw_o       (exe_isw)
  );

`ifdef SFU_ISSUE_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] stall_q;

  // Cycles where demand exists but the fence blocks issue; saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((state_q == ST_FENCED) && (|disp_valid) && !(&stall_q)) begin
      stall_q <= stall_q + PERF_CTR_BITS'(1);
    end
  end

  assign perf_fence_stalls = stall_q;
`endif

endmodule

// File: tb/tb_sfu_issue_arbiter.sv
// Directed bench for sfu_issue_arbiter (ISSUE_WIDTH=4, DATAW=128).
module tb_sfu_issue_arbiter;
  import VX_gpu_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 128;

  logic             clk;
  logic             reset;
  logic [NW-1:0]    disp_valid;
  logic [NW*DW-1:0] disp_data;
  logic [NW-1:0]    disp_fence;
  logic [NW-1:0]    disp_ready;
  logic             exe_valid;
  logic [DW-1:0]    exe_data;
  logic [1:0]       exe_isw;
  logic             exe_ready;
  logic             fence_clear;
  logic             fence_active;
`ifdef SFU_ISSUE_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_fence_stalls;
`endif

  int total = 0;
  int bad   = 0;

  sfu_issue_arbiter #(.ISSUE_WIDTH(NW), .DATAW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .disp_valid   (disp_valid),
    .disp_data    (disp_data),
    .disp_fence   (disp_fence),
    .disp_ready   (disp_ready),
    .exe_valid    (exe_valid),
    .exe_data     (exe_data),
    .exe_isw      (exe_isw),
    .exe_ready    (exe_ready),
    .fence_clear  (fence_clear),
    .fence_active (fence_active)
`ifdef SFU_ISSUE_ARB_PERF_EN
    ,
    .perf_fence_stalls (perf_fence_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pl(input int s);
    return {32'hC0DE_0000 | 32'(s), 96'(s * 7 + 1)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    disp_valid  = '0;
    disp_fence  = '0;
    fence_clear = 1'b0;
    exe_ready   = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    disp_valid  = 4'hF;
    disp_fence  = '0;
    fence_clear = 1'b0;
    exe_ready   = 1'b1;
    reset       = 1'b0;
    step();
    step();
    total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL rst_exe_valid got=%0h exp=0", exe_valid); end
    total++; if (exe_isw !== 2'd0) begin bad++; $display("FAIL rst_exe_isw got=%0h exp=0", exe_isw); end
    total++; if (exe_data !== '0) begin bad++; $display("FAIL rst_exe_data got=%0h exp=0", exe_data); end
    total++; if (fence_active !== 1'b0) begin bad++; $display("FAIL rst_fence got=%0h exp=0", fence_active); end
    total++; if (disp_ready !== 4'h0) begin bad++; $display("FAIL rst_disp_ready got=%0h exp=0", disp_ready); end
  endtask

  task automatic test_round_robin();
    do_reset();
    exe_ready  = 1'b1;
    disp_valid = 4'hF;
    #1;
    total++; if (disp_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%0h exp=1", disp_ready); end
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0h exp=1", i, exe_valid); end
      total++; if (exe_isw !== 2'(i % 4)) begin bad++; $display("FAIL rr_isw[%0d] got=%0h exp=%0h", i, exe_isw, i % 4); end
      total++; if (exe_data !== pl(i % 4)) begin bad++; $display("FAIL rr_data[%0d] got=%0h exp=%0h", i, exe_data, pl(i % 4)); end
    end
    disp_valid = '0;
    step();
    total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL rr_drained got=%0h exp=0", exe_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    exe_ready  = 1'b0;
    disp_valid = 4'b0110;
    #1;
    total++; if (disp_ready !== 4'b0010) begin bad++; $display("FAIL bp_ready0 got=%0h exp=2", disp_ready); end
    step();
    total++; if (disp_ready !== 4'b0100) begin bad++; $display("FAIL bp_ready1 got=%0h exp=4", disp_ready); end
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (disp_ready !== 4'b0000) begin bad++; $display("FAIL bp_full_ready[%0d] got=%0h exp=0", i, disp_ready); end
      total++; if (exe_isw !== 2'd1) begin bad++; $display("FAIL bp_hold_isw[%0d] got=%0h exp=1", i, exe_isw); end
      total++; if (exe_data !== pl(1)) begin bad++; $display("FAIL bp_hold_data[%0d] got=%0h exp=%0h", i, exe_data, pl(1)); end
      step();
    end
    disp_valid = '0;
    exe_ready  = 1'b1;
    step();
    total++; if (exe_valid !== 1'b1 || exe_isw !== 2'd2) begin bad++; $display("FAIL bp_drain2 got=%0h/%0h exp=1/2", exe_valid, exe_isw); end
    total++; if (exe_data !== pl(2)) begin bad++; $display("FAIL bp_drain2_data got=%0h exp=%0h", exe_data, pl(2)); end
    step();
    total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0h exp=0", exe_valid); end
  endtask

  task automatic test_fence();
    do_reset();
    exe_ready  = 1'b1;
    disp_valid = 4'b0010;
    step();
    disp_valid = 4'b1101;
    disp_fence = 4'b0100;
    #1;
    total++; if (disp_ready !== 4'b0100) begin bad++; $display("FAIL fn_grant2 got=%0h exp=4", disp_ready); end
    step();
    total++; if (fence_active !== 1'b1) begin bad++; $display("FAIL fn_active got=%0h exp=1", fence_active); end
    total++; if (exe_valid !== 1'b1 || exe_isw !== 2'd2) begin bad++; $display("FAIL fn_drain got=%0h/%0h exp=1/2", exe_valid, exe_isw); end
    disp_valid = 4'b1001;
    disp_fence = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (disp_ready !== 4'b0000) begin bad++; $display("FAIL fn_blocked[%0d] got=%0h exp=0", i, disp_ready); end
      step();
      total++; if (fence_active !== 1'b1) begin bad++; $display("FAIL fn_hold[%0d] got=%0h exp=1", i, fence_active); end
    end
    total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL fn_q_empty got=%0h exp=0", exe_valid); end
    fence_clear = 1'b1;
    #1;
    total++; if (disp_ready !== 4'b0000) begin bad++; $display("FAIL fn_clear_cycle got=%0h exp=0", disp_ready); end
    step();
    fence_clear = 1'b0;
    total++; if (fence_active !== 1'b0) begin bad++; $display("FAIL fn_cleared got=%0h exp=0", fence_active); end
    #1;
    total++; if (disp_ready !== 4'b1000) begin bad++; $display("FAIL fn_next_slot3 got=%0h exp=8", disp_ready); end
    step();
    disp_valid = '0;
    total++; if (exe_isw !== 2'd3) begin bad++; $display("FAIL fn_isw3 got=%0h exp=3", exe_isw); end
  endtask

  task automatic test_fence_collision();
    do_reset();
    exe_ready   = 1'b1;
    disp_valid  = 4'b0001;
    disp_fence  = 4'b0001;
    fence_clear = 1'b1;
    step();
    total++; if (fence_active !== 1'b1) begin bad++; $display("FAIL col_enter got=%0h exp=1", fence_active); end
    fence_clear = 1'b0;
    disp_valid  = '0;
    disp_fence  = '0;
    step();
    total++; if (fence_active !== 1'b1) begin bad++; $display("FAIL col_stay got=%0h exp=1", fence_active); end
    fence_clear = 1'b1;
    step();
    fence_clear = 1'b0;
    total++; if (fence_active !== 1'b0) begin bad++; $display("FAIL col_release got=%0h exp=0", fence_active); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    exe_ready  = 1'b0;
    disp_valid = 4'b0011;
    step();
    step();
    total++; if (disp_ready !== 4'b0000) begin bad++; $display("FAIL mid_full got=%0h exp=0", disp_ready); end
    total++; if (exe_valid !== 1'b1) begin bad++; $display("FAIL mid_valid got=%0h exp=1", exe_valid); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (exe_valid !== 1'b0) begin bad++; $display("FAIL mid_async got=%0h exp=0", exe_valid); end
    step();
    total++; if (exe_valid !== 1'b0 || fence_active !== 1'b0) begin bad++; $display("FAIL mid_held got=%0h/%0h exp=0/0", exe_valid, fence_active); end
    total++; if (disp_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_in_rst got=%0h exp=0", disp_ready); end
    reset = 1'b1;
    #1;
    total++; if (disp_ready !== 4'b0001) begin bad++; $display("FAIL mid_slot0_first got=%0h exp=1", disp_ready); end
    step();
    disp_valid = '0;
    total++; if (exe_isw !== 2'd0 || exe_data !== pl(0)) begin bad++; $display("FAIL mid_out got=%0h/%0h exp=0/%0h", exe_isw, exe_data, pl(0)); end
  endtask

`ifdef SFU_ISSUE_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    exe_ready  = 1'b1;
    disp_valid = 4'b0001;
    disp_fence = 4'b0001;
    step();
    disp_fence = '0;
    disp_valid = 4'b0010;
    for (int i = 0; i < 7; i++) step();
    total++; if (perf_fence_stalls !== PERF_CTR_BITS'(7)) begin bad++; $display("FAIL perf_7 got=%0d exp=7", perf_fence_stalls); end
    disp_valid = '0;
    for (int i = 0; i < 3; i++) step();
    total++; if (perf_fence_stalls !== PERF_CTR_BITS'(7)) begin bad++; $display("FAIL perf_idle got=%0d exp=7", perf_fence_stalls); end
    fence_clear = 1'b1;
    step();
    fence_clear = 1'b0;
  endtask
`endif

  initial begin
    for (int s = 0; s < int'(NW); s++) disp_data[s*DW +: DW] = pl(s);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fence();
    test_fence_collision();
    test_reset_mid();
`ifdef SFU_ISSUE_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfu_issue_arbiter.md
Name: sfu_issue_arbiter

Overview:
- Upstream neighbour of the SFU execute stage.
- Arbitrates `ISSUE_WIDTH` dispatch slots round-robin into one SFU execute stream.
- Buffers the granted op in a 2-entry elastic output queue.
- Enforces a fence: a fenced op (warp-control such as barrier/join) blocks all further grants until the commit side pulses `fence_clear`.

Parameters:
- ISSUE_WIDTH, 4, number of dispatch slots (≥1).
- DATAW, 128, opaque per-op payload width (uuid, wid, tmask, op_type, operands).
- ISW_W, `CLOG2(ISSUE_WIDTH)` (min 1), slot index width, derived.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- disp_valid  in  ISSUE_WIDTH  per-slot op valid.
- disp_data  in  ISSUE_WIDTH*DATAW  per-slot payload, slot i at [i*DATAW +: DATAW].
- disp_fence  in  ISSUE_WIDTH  per-slot "op is fenced" flag.
- disp_ready  out  ISSUE_WIDTH  per-slot accept.
- exe_valid  out  1  execute op valid.
- exe_data  out  DATAW  execute payload.
- exe_isw  out  ISW_W  originating slot index.
- exe_ready  in  1  execute accept.
- fence_clear  in  1  one-cycle pulse: fenced op has committed.
- fence_active  out  1  high while fenced.

Behaviour:
- Reset (reset==0, async): queue empty, exe_valid=0, exe_data=0, exe_isw=0, disp_ready=0, rr pointer=0, state=OPEN, fence_active=0.
- FSM states:
  - OPEN: arbitration enabled.
  - FENCED: no grants.
- Transitions:
  - OPEN→FENCED on the cycle a grant has disp_fence=1.
  - FENCED→OPEN on fence_clear=1.
  - fence_clear while OPEN is ignored.
  - A fence grant and fence_clear in the same cycle: the new fence wins; state stays/enters FENCED.
- Grant rule:
  - Grants happen only in OPEN with queue not full.
  - Winner is the first valid slot scanning from rr pointer upward, with wrap-around (ISSUE_WIDTH-1 wraps to 0).
  - disp_ready[winner]=1 and all other disp_ready bits are 0; at most one handshake per cycle.
  - disp_ready is combinational from disp_valid, state and queue count. No combinational path exists from exe_ready.
  - After a grant, the rr pointer becomes winner+1 (mod ISSUE_WIDTH). With no grant, the pointer holds.
- Queue:
  - 2-entry FIFO of {data, isw}; exe_* is driven from the head, registered.
  - Latency: op accepted at cycle N appears on exe_valid at N+1 earliest.
  - Full=2 entries: no grant.
  - Push and pop in the same cycle when count==2 is not allowed, since no grant is made when full.
  - Push and pop in the same cycle when count==1 leaves count at 1.
- Handshake: valid/ready. exe_data and exe_isw hold stable while exe_valid && !exe_ready.
- fence_active = (state==FENCED).
- An already-queued op behind a fence still drains; the fence gates only new grants.
- ISSUE_WIDTH==1: the arbiter degenerates to a pass-through grant; exe_isw=0.

Optional Feature:
- Macro SFU_ISSUE_ARB_PERF_EN.
- When defined, add output perf_fence_stalls (`PERF_CTR_BITS` wide). It increments each cycle that state==FENCED and |disp_valid, saturates at all-ones, and resets to 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package VX_gpu_pkg holds the fence op-type predicate (inst_sfu_is_fence) and the ISW_W derivation helper.
- The fence flag is computed by the instantiating SFU wrapper with that predicate; this block stays payload-agnostic.
- One natural sub-module: sfu_issue_arbiter_queue, the 2-entry elastic FIFO with async active-low reset.
- The round-robin grant logic stays inline.

Test Plan:
- Reset mid-traffic: queue holding 2 ops, assert reset=0 → next edge exe_valid=0, fence_active=0, pointer=0; after release, slot 0 wins first.
- Round-robin fairness: ISSUE_WIDTH=4, all slots valid, exe_ready=1, no fences → exe_isw sequence 0,1,2,3,0, one op per cycle after 1-cycle latency.
- Backpressure: exe_ready=0 with slots 1,2 valid → two grants (1 then 2), then disp_ready=0; exe_data holds slot 1 payload stable; exe_ready=1 drains 1 then 2.
- Fence: slot 2 fenced op granted, slots 0,3 valid → fence_active=1, no grants for 5 cycles; fence_clear pulse → next grant is slot 3 (pointer=3).
- Simultaneous fence_clear and new fence grant → state remains FENCED, fence_active stays 1.
- With SFU_ISSUE_ARB_PERF_EN: 7 fenced cycles with pending valid → perf_fence_stalls=7; 3 fenced cycles with no valid → unchanged.
